demux4_3_buf: RTL and testbench

DEMUX4_3_BUF -- requirements
Module: demux4_3_buf

---
 rtl/demux4_3_buf.sv | 71 +++++++
 tb/tb_demux4_3_buf.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/demux4_3_buf.sv
// Four-way demultiplexer; each output channel has its own 2-entry FIFO.
// A word is steered by in_s and may be taken at y while other channels push or pop.
module demux4_3_buf #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_s,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] y,
  output logic [3:0]         y_valid,
  input  logic [3:0]         y_ready,
  output logic [7:0]         count
);

  logic [WIDTH-1:0] mem [4][2];
  logic [1:0]       cnt [4];
  logic [3:0]       wp;
  logic [3:0]       rp;
  logic [3:0]       push;
  logic [3:0]       pop;

  always_comb begin
    in_ready = (cnt[in_s] != 2'd2);
    push     = '0;
    pop      = '0;
    y        = '0;
    y_valid  = '0;
    count    = '0;
    for (int k = 0; k < 4; k++) begin
      y_valid[k]       = (cnt[k] != 2'd0);
      push[k]          = in_valid && in_ready && (in_s == 2'(k));
      pop[k]           = y_valid[k] && y_ready[k];
      count[2*k +: 2]  = cnt[k];
      // Stale storage stays hidden behind y_valid.
      if (y_valid[k])
        y[WIDTH*k +: WIDTH] = mem[k][rp[k]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      for (int k = 0; k < 4; k++)
        cnt[k] <= 2'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push[k])
          wp[k] <= ~wp[k];
        if (pop[k])
          rp[k] <= ~rp[k];
        unique case ({push[k], pop[k]})
          2'b10:   cnt[k] <= cnt[k] + 2'd1;
          2'b01:   cnt[k] <= cnt[k] - 2'd1;
          default: cnt[k] <= cnt[k];
        endcase
      end
    end
  end

  // Storage needs no reset; writes are gated by push.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (push[k])
        mem[k][wp[k]] <= in_data;
  end

endmodule

// File: tb/tb_demux4_3_buf.sv
// Directed and random stimulus for demux4_3_buf.
// A per-channel queue model predicts every output word and occupancy.
module tb_demux4_3_buf;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic [1:0]     in_s;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] y;
  logic [3:0]     y_valid;
  logic [3:0]     y_ready;
  logic [7:0]     count;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] q [4][$];

  demux4_3_buf #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_s     (in_s),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs(input logic [1:0] s);
    logic [4*W-1:0] ey;
    logic [3:0]     ev;
    logic [7:0]     ec;
    ey = '0;
    ev = '0;
    ec = '0;
    for (int k = 0; k < 4; k++) begin
      ev[k] = (q[k].size() > 0);
      ec[2*k +: 2] = 2'(q[k].size());
      if (ev[k])
        ey[W*k +: W] = q[k][0];
    end
    check("y_valid", 32'(y_valid), 32'(ev));
    check("y", 32'(y), 32'(ey));
    check("count", 32'(count), 32'(ec));
    check("in_ready", 32'(in_ready), 32'(q[s].size() < 2));
  endtask

  // Drive one cycle, check pre-edge outputs, update model, advance.
  task automatic step(input logic r, input logic v, input logic [1:0] s,
                      input logic [W-1:0] d, input logic [3:0] yr);
    logic         rdy;
    logic [W-1:0] w;
    rst_n    = r;
    in_valid = v;
    in_s     = s;
    in_data  = d;
    y_ready  = yr;
    #1;
    compare_outputs(s);
    rdy = (q[s].size() < 2);
    if (!r) begin
      for (int k = 0; k < 4; k++)
        q[k].delete();
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (yr[k] && q[k].size() > 0) begin
          w = q[k].pop_front();
          check("pop_word", 32'(y[W*k +: W]), 32'(w));
        end
      end
      if (v && rdy)
        q[s].push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_s     = '0;
    in_data  = '0;
    y_ready  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // In reset with a push offered: nothing accepted, in_ready high.
    step(0, 1, 2, 3'b110, 4'b0000);
    step(0, 1, 1, 3'b011, 4'b1111);

    // Single push to channel 2.
    step(1, 1, 2, 3'b101, 4'b0000);
    step(1, 0, 2, 3'b000, 4'b0000);
    check("ch2_head", 32'(y[8:6]), 32'h5);
    step(1, 0, 2, 3'b000, 4'b0100);

    // Fill channel 0, blocked push, then drain in order.
    step(1, 1, 0, 3'b001, 4'b0000);
    step(1, 1, 0, 3'b010, 4'b0000);
    check("ch0_full_rdy", 32'(in_ready), 32'h0);
    step(1, 1, 0, 3'b111, 4'b0000);
    step(1, 0, 1, 3'b000, 4'b0000);
    step(1, 0, 0, 3'b000, 4'b0001);
    step(1, 0, 0, 3'b000, 4'b0001);
    step(1, 0, 0, 3'b000, 4'b0001);
    check("ch0_empty_y", 32'(y[2:0]), 32'h0);

    // Push and pop on a one-word channel.
    step(1, 1, 3, 3'b111, 4'b0000);
    step(1, 1, 3, 3'b011, 4'b1000);
    step(1, 0, 3, 3'b000, 4'b0000);
    check("ch3_replace", 32'(y[11:9]), 32'h3);
    step(1, 0, 3, 3'b000, 4'b1000);

    // Push on one channel while popping others.
    step(1, 1, 1, 3'b100, 4'b0000);
    step(1, 1, 2, 3'b110, 4'b0000);
    step(1, 1, 3, 3'b001, 4'b0110);
    step(1, 0, 0, 3'b000, 4'b1000);

    // Reset overrides a push while two channels are full.
    step(1, 1, 0, 3'b001, 4'b0000);
    step(1, 1, 0, 3'b010, 4'b0000);
    step(1, 1, 1, 3'b011, 4'b0000);
    step(1, 1, 1, 3'b100, 4'b0000);
    step(0, 1, 2, 3'b101, 4'b1111);
    step(1, 0, 0, 3'b000, 4'b0000);
    check("rst_y", 32'(y), 32'h0);

    for (int i = 0; i < 1024; i++)
      step(1, 1'($urandom), 2'($urandom), 3'($urandom), 4'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
